mul_matrix_seq: RTL and testbench

MUL_MATRIX_SEQ -- requirements
Module: mul_matrix_seq

---
 rtl/mul_matrix_seq.sv | 111 +++++++++++
 tb/tb_mul_matrix_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_matrix_seq.sv
// Sequential 5x2 * 2x3 matrix multiplier built around one shared W x W multiplier.
// Each C element takes two cycles: the first product goes into acc, then acc plus the second product is stored.
module mul_matrix_seq #(
    parameter int W = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [10*W-1:0] A,
    input  logic [6*W-1:0]  B,
    output logic            busy,
    output logic            done,
    output logic [15*W-1:0] C
);
    typedef enum logic [1:0] {IDLE, MUL0, MUL1, DONE} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_row;
    logic [1:0]      r_col;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_a   [10];
    logic [W-1:0]    r_b   [6];
    logic [W-1:0]    r_buf [15];
    logic [15*W-1:0] r_c;

    logic            w_capture;
    logic            w_last;
    logic [3:0]      w_ibuf;
    logic [W-1:0]    w_mul_a;
    logic [W-1:0]    w_mul_b;
    logic [W-1:0]    w_prod;
    logic [W-1:0]    w_sum;
    logic [15*W-1:0] w_c_next;

    function automatic logic [W-1:0] f_wrap_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return x + y;  // carry out dropped: result is mod 2^W
    endfunction

    assign w_capture = (r_state == IDLE) && start;
    assign w_last    = (r_row == 3'd4) && (r_col == 2'd2);
    assign w_ibuf    = {r_row, 1'b0} + {1'b0, r_row} + {2'b00, r_col};

    // Operand select feeding the single multiplier: column 0 terms in MUL0, column 1 terms in MUL1.
    assign w_mul_a = (r_state == MUL1) ? r_a[{r_row, 1'b1}] : r_a[{r_row, 1'b0}];
    assign w_mul_b = (r_state == MUL1) ? r_b[{1'b0, r_col} + 3'd3] : r_b[{1'b0, r_col}];
    assign w_prod  = w_mul_a * w_mul_b;
    assign w_sum   = f_wrap_add(r_acc, w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = MUL0;
            MUL0:    w_next = MUL1;
            MUL1:    w_next = w_last ? DONE : MUL0;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= 3'd0;
            r_col <= 2'd0;
            r_acc <= '0;
            r_c   <= '0;
        end else begin
            if (w_capture) begin
                r_row <= 3'd0;
                r_col <= 2'd0;
            end else if (r_state == MUL1) begin
                if (r_col == 2'd2) begin
                    r_col <= 2'd0;
                    r_row <= w_last ? 3'd0 : r_row + 3'd1;
                end else begin
                    r_col <= r_col + 2'd1;
                end
            end
            if (r_state == MUL0) r_acc <= w_prod;
            if ((r_state == MUL1) && w_last) r_c <= w_c_next;
        end
    end

    // Operand copies and partial results are plain data: never reset, only written when meaningful.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < 10; i++) r_a[i] <= A[(10-i)*W-1 -: W];
            for (int i = 0; i < 6; i++)  r_b[i] <= B[(6-i)*W-1 -: W];
        end
        if (r_state == MUL1) r_buf[w_ibuf] <= w_sum;
    end

    // The last element bypasses the buffer so C loads on the same edge it is computed.
    always_comb begin
        w_c_next = '0;
        for (int i = 0; i < 14; i++) w_c_next[(15-i)*W-1 -: W] = r_buf[i];
        w_c_next[W-1:0] = w_sum;
    end

    assign C    = r_c;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_mul_matrix_seq.sv
// Scoreboard bench for mul_matrix_seq: expected C pushed at start, popped when done is seen.
module tb_mul_matrix_seq;
    localparam int W  = 15;
    localparam int CW = 15 * W;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [10*W-1:0] A     = '0;
    logic [6*W-1:0]  B     = '0;
    logic            busy;
    logic            done;
    logic [CW-1:0]   C;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] sb[$];

    mul_matrix_seq #(.W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .C    (C)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] model(input logic [10*W-1:0] a, input logic [6*W-1:0] b);
        logic [CW-1:0]   res;
        logic [10*W-1:0] ta;
        logic [6*W-1:0]  bb;
        longint          ar0, ar1, b0, b1, s;
        longint          mask;
        res  = '0;
        mask = (longint'(1) << W) - 1;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 3; k++) begin
                ta  = a >> ((9 - 2*r) * W); ar0 = longint'(ta[W-1:0]);
                ta  = a >> ((8 - 2*r) * W); ar1 = longint'(ta[W-1:0]);
                bb  = b >> ((5 - k) * W);   b0  = longint'(bb[W-1:0]);
                bb  = b >> ((2 - k) * W);   b1  = longint'(bb[W-1:0]);
                s   = (ar0 * b0 + ar1 * b1) & mask;
                res = (res << W) | CW'(s);
            end
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [10*W-1:0] a, input logic [6*W-1:0] b);
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back(model(a, b));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = -1;
        nbusy = 0;
        for (int t = 1; t <= 40 && cyc < 0; t++) begin
            tick();
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) cyc = t;
        end
    endtask

    task automatic rand_ops(output logic [10*W-1:0] a, output logic [6*W-1:0] b);
        for (int i = 0; i < 10; i++) a[i*W +: W] = W'($urandom);
        for (int i = 0; i < 6; i++)  b[i*W +: W] = W'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (C !== '0) begin n_fail++; $display("FAIL reset_C: got %h expected 0", C); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ones();
        logic [10*W-1:0] a;
        logic [6*W-1:0]  b;
        logic [CW-1:0]   exp, all4;
        int              cyc, nb, hi;
        for (int i = 0; i < 10; i++) a[i*W +: W] = W'(1);
        for (int i = 0; i < 6; i++)  b[i*W +: W] = W'(2);
        for (int i = 0; i < 15; i++) all4[i*W +: W] = W'(4);
        do_start(a, b);
        hi = (busy === 1'b1) ? 1 : 0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ones_busy_start: got %b expected 1", busy); end
        wait_done(cyc, nb);
        n_tests++; if (cyc != 30) begin n_fail++; $display("FAIL ones_latency: got %0d expected 30", cyc); end
        n_tests++; if (hi + nb != 31) begin n_fail++; $display("FAIL ones_busy_cycles: got %0d expected 31", hi + nb); end
        if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
        n_tests++; if (C !== exp) begin n_fail++; $display("FAIL ones_C: got %h expected %h", C, exp); end
        n_tests++; if (C !== all4) begin n_fail++; $display("FAIL ones_all4: got %h expected %h", C, all4); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ones_done_clear: got %b expected 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ones_busy_clear: got %b expected 0", busy); end
    endtask

    task automatic test_ramp();
        logic [10*W-1:0] a;
        logic [6*W-1:0]  b;
        logic [CW-1:0]   exp;
        int              cyc, nb;
        for (int r = 0; r < 5; r++) begin
            a[(9-2*r)*W +: W] = W'(r + 1);
            a[(8-2*r)*W +: W] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            b[(5-k)*W +: W] = W'(k + 1);
            b[(2-k)*W +: W] = W'(7);
        end
        do_start(a, b);
        wait_done(cyc, nb);
        n_tests++; if (cyc != 30) begin n_fail++; $display("FAIL ramp_latency: got %0d expected 30", cyc); end
        if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
        n_tests++; if (C !== exp) begin n_fail++; $display("FAIL ramp_C: got %h expected %h", C, exp); end
        n_tests++; if (C[W-1:0] !== W'(15)) begin n_fail++; $display("FAIL ramp_c42: got %0d expected 15", C[W-1:0]); end
        n_tests++; if (C[CW-1 -: W] !== W'(1)) begin n_fail++; $display("FAIL ramp_c00: got %0d expected 1", C[CW-1 -: W]); end
        tick();
    endtask

    task automatic test_wrap();
        logic [10*W-1:0] a;
        logic [6*W-1:0]  b;
        logic [CW-1:0]   exp, want;
        int              cyc, nb;
        a = '0;
        b = '0;
        a[9*W +: W] = 15'h7FFF;
        a[8*W +: W] = 15'h0001;
        b[5*W +: W] = 15'h7FFF;
        b[2*W +: W] = 15'h0001;
        want = '0;
        want[14*W +: W] = 15'h0002;
        do_start(a, b);
        wait_done(cyc, nb);
        n_tests++; if (cyc != 30) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 30", cyc); end
        if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
        n_tests++; if (C !== exp) begin n_fail++; $display("FAIL wrap_C_model: got %h expected %h", C, exp); end
        n_tests++; if (C !== want) begin n_fail++; $display("FAIL wrap_C: got %h expected %h", C, want); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] exp;
        int            ndone, last_t;
        ndone  = 0;
        last_t = -1;
        start  = 1'b1;
        for (int t = 0; t < 96; t++) begin
            for (int i = 0; i < 10; i++) A[i*W +: W] = W'($urandom);
            for (int i = 0; i < 6; i++)  B[i*W +: W] = W'($urandom);
            if (t % 32 == 0) sb.push_back(model(A, B));
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
                n_tests++; if (C !== exp) begin n_fail++; $display("FAIL b2b_C: got %h expected %h", C, exp); end
                n_tests++; if (t % 32 != 30) begin n_fail++; $display("FAIL b2b_done_phase: got %0d expected 30", t % 32); end
                if (last_t >= 0) begin
                    n_tests++; if (t - last_t != 32) begin n_fail++; $display("FAIL b2b_period: got %0d expected 32", t - last_t); end
                end
                last_t = t;
            end
        end
        start = 1'b0;
        tick();
        n_tests++; if (ndone != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", ndone); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_midreset();
        logic [10*W-1:0] a;
        logic [6*W-1:0]  b;
        logic [CW-1:0]   exp;
        int              cyc, nb, nd;
        rand_ops(a, b);
        do_start(a, b);
        repeat (11) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrst_done: got %b expected 0", done); end
        n_tests++; if (C !== '0) begin n_fail++; $display("FAIL mrst_C: got %h expected 0", C); end
        sb.delete();
        nd = 0;
        repeat (3) begin
            tick();
            if (done === 1'b1) nd++;
        end
        n_tests++; if (nd != 0) begin n_fail++; $display("FAIL mrst_no_done: got %0d expected 0", nd); end
        rst_n = 1'b1;
        rand_ops(a, b);
        do_start(a, b);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mrst_first_edge_start: got %b expected 1", busy); end
        wait_done(cyc, nb);
        n_tests++; if (cyc != 30) begin n_fail++; $display("FAIL mrst_latency: got %0d expected 30", cyc); end
        if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
        n_tests++; if (C !== exp) begin n_fail++; $display("FAIL mrst_C_after: got %h expected %h", C, exp); end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [10*W-1:0] a;
        logic [6*W-1:0]  b;
        logic [CW-1:0]   exp, held;
        int              cyc;
        rand_ops(a, b);
        do_start(a, b);
        held = C;
        cyc  = -1;
        for (int t = 1; t <= 40 && cyc < 0; t++) begin
            for (int i = 0; i < 10; i++) A[i*W +: W] = W'($urandom);
            for (int i = 0; i < 6; i++)  B[i*W +: W] = W'($urandom);
            start = (t == 2) || (t == 5);
            tick();
            if (done === 1'b1) cyc = t;
            else if (t == 20) begin
                n_tests++; if (C !== held) begin n_fail++; $display("FAIL ign_C_hold: got %h expected %h", C, held); end
            end
        end
        start = 1'b0;
        n_tests++; if (cyc != 30) begin n_fail++; $display("FAIL ign_latency: got %0d expected 30", cyc); end
        if (sb.size() > 0) exp = sb.pop_front(); else exp = 'x;
        n_tests++; if (C !== exp) begin n_fail++; $display("FAIL ign_C: got %h expected %h", C, exp); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_done_start: got %b expected 0", busy); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue: got %b expected 0", busy); end
        n_tests++; if (C !== exp) begin n_fail++; $display("FAIL ign_C_stable: got %h expected %h", C, exp); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_wrap();
        test_back_to_back();
        test_midreset();
        test_ignore_start();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
